// File: rtl/ts_link_monitor_if.sv
// Link-side bundle for ts_link_monitor: raw lane word in, lock status, payload and counters out.
// master = lane source / slow-control side, slave = the monitor.
interface ts_link_monitor_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  logic [15:0]          rx_d;
  logic [1:0]           rx_k;
  logic                 rx_err;
  logic                 clear_cnt;
  logic                 locked;
  logic                 align;
  logic [7:0]           pay_d;
  logic                 pay_valid;
  logic [CNT_WIDTH-1:0] code_err_cnt;
  logic [CNT_WIDTH-1:0] seq_err_cnt;
  logic [CNT_WIDTH-1:0] unlock_cnt;

  modport master (
    output rx_d, rx_k, rx_err, clear_cnt,
    input  locked, align, pay_d, pay_valid, code_err_cnt, seq_err_cnt, unlock_cnt
  );

  modport slave (
    input  rx_d, rx_k, rx_err, clear_cnt,
    output locked, align, pay_d, pay_valid, code_err_cnt, seq_err_cnt, unlock_cnt
  );
endinterface

// File: rtl/ts_link_monitor.sv
// K28.5 comma alignment, hunt/verify/locked tracking and link statistics for one rx lane.
// Define TS_LINK_SEQ_CHECK_EN to build the payload sequence checker and seq_err_cnt.
module ts_link_monitor #(
  parameter int unsigned LOCK_COUNT   = 16,
  parameter int unsigned UNLOCK_COUNT = 4,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic               rx_clk,
  input  logic               reset,
  ts_link_monitor_if.slave   link_io
);

  localparam logic [1:0] StHunt   = 2'd0;
  localparam logic [1:0] StVerify = 2'd1;
  localparam logic [1:0] StLocked = 2'd2;

  localparam logic [7:0] LockCnt   = 8'(LOCK_COUNT);
  localparam logic [7:0] UnlockCnt = 8'(UNLOCK_COUNT);
  localparam logic [7:0] Comma     = 8'hBC;

  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CntOne;
  endfunction

  logic [1:0]           state_q, state_d;
  logic                 align_q, align_d;
  logic [7:0]           good_cnt_q, good_cnt_d;
  logic [7:0]           miss_cnt_q, miss_cnt_d;
  logic [7:0]           prev_d_hi_q;
  logic                 prev_k_hi_q;
  logic                 prev_err_q;
  logic [7:0]           pay_d_q, pay_d_d;
  logic                 pay_valid_q, pay_valid_d;
  logic [CNT_WIDTH-1:0] code_err_q, code_err_d;
  logic [CNT_WIDTH-1:0] unlock_q, unlock_d;
  logic                 unlock_inc;

  logic [15:0] al_d;
  logic [1:0]  al_k;
  logic        al_err;
  logic        al_good;
  logic        hunt_lo, hunt_hi;

  // With align=1 the word straddles two cycles: byte 0 comes from the stage register.
  always_comb begin
    if (align_q) begin
      al_d   = {link_io.rx_d[7:0], prev_d_hi_q};
      al_k   = {link_io.rx_k[0], prev_k_hi_q};
      al_err = link_io.rx_err | prev_err_q;
    end else begin
      al_d   = link_io.rx_d;
      al_k   = link_io.rx_k;
      al_err = link_io.rx_err;
    end
    al_good = (al_k == 2'b01) && (al_d[7:0] == Comma) && !al_err;
  end

  assign hunt_lo = (link_io.rx_k == 2'b01) && (link_io.rx_d[7:0] == Comma);
  assign hunt_hi = (link_io.rx_k == 2'b10) && (link_io.rx_d[15:8] == Comma);

  always_comb begin
    state_d     = state_q;
    align_d     = align_q;
    good_cnt_d  = good_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    pay_d_d     = al_d[15:8];
    pay_valid_d = 1'b0;
    unlock_inc  = 1'b0;
    case (state_q)
      StHunt: begin
        if (hunt_lo || hunt_hi) begin
          align_d    = hunt_hi;
          good_cnt_d = 8'd1;
          state_d    = StVerify;
        end
      end
      StVerify: begin
        if (al_good) begin
          good_cnt_d = good_cnt_q + 8'd1;
          if (good_cnt_d == LockCnt) begin
            state_d    = StLocked;
            miss_cnt_d = 8'd0;
          end
        end else begin
          state_d = StHunt;
        end
      end
      StLocked: begin
        if (al_good) begin
          miss_cnt_d  = 8'd0;
          pay_valid_d = 1'b1;
        end else begin
          miss_cnt_d = miss_cnt_q + 8'd1;
          if (miss_cnt_d == UnlockCnt) begin
            state_d    = StHunt;
            unlock_inc = 1'b1;
          end
        end
      end
      default: state_d = StHunt;
    endcase
  end

  // Clear beats a same-cycle increment.
  always_comb begin
    code_err_d = link_io.clear_cnt ? '0 :
                 link_io.rx_err    ? sat_inc(code_err_q) : code_err_q;
    unlock_d   = link_io.clear_cnt ? '0 :
                 unlock_inc        ? sat_inc(unlock_q) : unlock_q;
  end

  always_ff @(posedge rx_clk) begin
    if (reset) begin
      state_q     <= StHunt;
      align_q     <= 1'b0;
      good_cnt_q  <= 8'd0;
      miss_cnt_q  <= 8'd0;
      prev_d_hi_q <= 8'd0;
      prev_k_hi_q <= 1'b0;
      prev_err_q  <= 1'b0;
      pay_d_q     <= 8'd0;
      pay_valid_q <= 1'b0;
      code_err_q  <= '0;
      unlock_q    <= '0;
    end else begin
      state_q     <= state_d;
      align_q     <= align_d;
      good_cnt_q  <= good_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      prev_d_hi_q <= link_io.rx_d[15:8];
      prev_k_hi_q <= link_io.rx_k[1];
      prev_err_q  <= link_io.rx_err;
      pay_d_q     <= pay_d_d;
      pay_valid_q <= pay_valid_d;
      code_err_q  <= code_err_d;
      unlock_q    <= unlock_d;
    end
  end

`ifdef TS_LINK_SEQ_CHECK_EN
  logic                 seq_seeded_q, seq_seeded_d;
  logic [7:0]           seq_last_q, seq_last_d;
  logic [CNT_WIDTH-1:0] seq_err_q, seq_err_d;
  logic                 seq_miss;

  // A mismatch reseeds from the received byte; it never affects lock tracking.
  always_comb begin
    seq_seeded_d = seq_seeded_q;
    seq_last_d   = seq_last_q;
    seq_miss     = 1'b0;
    if (state_q != StLocked) begin
      seq_seeded_d = 1'b0;
    end else if (al_good) begin
      seq_miss     = seq_seeded_q && (al_d[15:8] != seq_last_q + 8'd1);
      seq_seeded_d = 1'b1;
      seq_last_d   = al_d[15:8];
    end
    seq_err_d = link_io.clear_cnt ? '0 :
                seq_miss          ? sat_inc(seq_err_q) : seq_err_q;
  end

  always_ff @(posedge rx_clk) begin
    if (reset) begin
      seq_seeded_q <= 1'b0;
      seq_last_q   <= 8'd0;
      seq_err_q    <= '0;
    end else begin
      seq_seeded_q <= seq_seeded_d;
      seq_last_q   <= seq_last_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign link_io.seq_err_cnt = seq_err_q;
`else
  assign link_io.seq_err_cnt = '0;
`endif

  assign link_io.locked       = (state_q == StLocked);
  assign link_io.align        = align_q;
  assign link_io.pay_d        = pay_d_q;
  assign link_io.pay_valid    = pay_valid_q;
  assign link_io.code_err_cnt = code_err_q;
  assign link_io.unlock_cnt   = unlock_q;

endmodule

// File: tb/tb_ts_link_monitor.sv
// Scoreboard bench for ts_link_monitor: per-word expectations queued at drive time,
// compared one clock later; counters are checked directly at phase boundaries.
module tb_ts_link_monitor;

`ifdef TS_LINK_SEQ_CHECK_EN
  localparam int unsigned SeqExp = 1;
`else
  localparam int unsigned SeqExp = 0;
`endif

  typedef struct packed {
    logic       ce;
    logic       ev;
    logic [7:0] ep;
    logic       el;
  } exp_t;

  logic rx_clk;
  logic reset;
  int   n_total;
  int   n_bad;
  exp_t sb_q[$];

  ts_link_monitor_if #(.CNT_WIDTH(16)) link_if ();

  ts_link_monitor #(
    .LOCK_COUNT  (16),
    .UNLOCK_COUNT(4),
    .CNT_WIDTH   (16)
  ) u_dut (
    .rx_clk (rx_clk),
    .reset  (reset),
    .link_io(link_if.slave)
  );

  initial begin
    rx_clk = 1'b0;
    forever #5 rx_clk = ~rx_clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; the expected output for this word is queued now.
  task automatic drive(input logic [15:0] d, input logic [1:0] k, input logic err,
                       input logic clr, input logic rst, input logic ce, input logic ev,
                       input logic [7:0] ep, input logic el);
    exp_t e;
    @(negedge rx_clk);
    link_if.rx_d      = d;
    link_if.rx_k      = k;
    link_if.rx_err    = err;
    link_if.clear_cnt = clr;
    reset             = rst;
    e.ce = ce;
    e.ev = ev;
    e.ep = ep;
    e.el = el;
    sb_q.push_back(e);
  endtask

  task automatic check_counters(input string tag, input logic [15:0] code,
                                input logic [15:0] seq, input logic [15:0] unl);
    @(posedge rx_clk);
    #2;
    check_val({tag, "_code_err"}, 32'(link_if.code_err_cnt), 32'(code));
    check_val({tag, "_seq_err"}, 32'(link_if.seq_err_cnt), 32'(seq));
    check_val({tag, "_unlock"}, 32'(link_if.unlock_cnt), 32'(unl));
  endtask

  function automatic logic [7:0] shifted_pay(input int j);
    return 8'(32'hF0 + j + ((j >= 33) ? 1 : 0));
  endfunction

  initial begin
    forever begin
      exp_t e;
      @(posedge rx_clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.ce) begin
          check_val("locked", 32'(link_if.locked), 32'(e.el));
          check_val("pay_valid", 32'(link_if.pay_valid), 32'(e.ev));
          if (e.ev) check_val("pay_d", 32'(link_if.pay_d), 32'(e.ep));
        end
      end
    end
  end

  initial begin
    n_total           = 0;
    n_bad             = 0;
    reset             = 1'b1;
    link_if.rx_d      = 16'h0;
    link_if.rx_k      = 2'b00;
    link_if.rx_err    = 1'b0;
    link_if.clear_cnt = 1'b0;

    // Reset state
    repeat (2) drive(16'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0, 1'b0);
    @(posedge rx_clk);
    #2;
    check_val("rst_locked", 32'(link_if.locked), 32'd0);
    check_val("rst_align", 32'(link_if.align), 32'd0);
    check_val("rst_pay_d", 32'(link_if.pay_d), 32'd0);
    check_val("rst_pay_valid", 32'(link_if.pay_valid), 32'd0);
    check_val("rst_code_err", 32'(link_if.code_err_cnt), 32'd0);
    check_val("rst_seq_err", 32'(link_if.seq_err_cnt), 32'd0);
    check_val("rst_unlock", 32'(link_if.unlock_cnt), 32'd0);

    // Aligned stream {n, BC}: lock after word 16, payload valid from word 17
    for (int i = 0; i < 40; i++)
      drive({8'(i), 8'hBC}, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, i >= 16, 8'(i), i >= 15);
    @(posedge rx_clk);
    #2;
    check_val("p1_align", 32'(link_if.align), 32'd0);
    check_val("p1_code_err", 32'(link_if.code_err_cnt), 32'd0);
    check_val("p1_seq_err", 32'(link_if.seq_err_cnt), 32'd0);
    check_val("p1_unlock", 32'(link_if.unlock_cnt), 32'd0);

    // Three bad words keep lock, then four consecutive bad words drop it
    for (int j = 0; j < 3; j++)
      drive({8'd40, 8'hBC}, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0, 1'b1);
    for (int i = 40; i < 48; i++)
      drive({8'(i), 8'hBC}, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'(i), 1'b1);
    check_counters("p2a", 16'd3, 16'd0, 16'd0);
    for (int j = 0; j < 4; j++)
      drive({8'd48, 8'hBC}, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0, j < 3);
    check_counters("p2b", 16'd7, 16'd0, 16'd1);

    // Comma in byte 1: payload wraps FF->00, then one skipped value 0x10->0x12
    for (int t = 0; t < 41; t++)
      drive({8'hBC, shifted_pay(t - 1)}, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, t >= 16,
            shifted_pay(t - 1), t >= 15);
    @(posedge rx_clk);
    #2;
    check_val("p3_align", 32'(link_if.align), 32'd1);
    check_val("p3_seq_err", 32'(link_if.seq_err_cnt), 32'(SeqExp));
    check_val("p3_unlock", 32'(link_if.unlock_cnt), 32'd1);
    check_val("p3_code_err", 32'(link_if.code_err_cnt), 32'd7);

    // Error counter saturation, then clear colliding with an error
    for (int i = 0; i < 65541; i++)
      drive(16'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 1'b0);
    check_counters("sat", 16'hFFFF, 16'(SeqExp), 16'd2);
    drive(16'h0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 1'b0);
    check_counters("clr", 16'd0, 16'd0, 16'd0);
    drive(16'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 1'b0);
    check_counters("post_clr", 16'd1, 16'd0, 16'd0);

    // Relock, then reset while locked with a nonzero counter
    for (int i = 0; i < 20; i++)
      drive({8'(8'h40 + i), 8'hBC}, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, i >= 16,
            8'(8'h40 + i), i >= 15);
    drive({8'h54, 8'hBC}, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0, 1'b0);
    @(posedge rx_clk);
    #2;
    check_val("mrst_align", 32'(link_if.align), 32'd0);
    check_val("mrst_pay_d", 32'(link_if.pay_d), 32'd0);
    check_val("mrst_pay_valid", 32'(link_if.pay_valid), 32'd0);
    check_val("mrst_code_err", 32'(link_if.code_err_cnt), 32'd0);
    check_val("mrst_seq_err", 32'(link_if.seq_err_cnt), 32'd0);
    check_val("mrst_unlock", 32'(link_if.unlock_cnt), 32'd0);
    drive(16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0, 1'b0);

    repeat (2) @(posedge rx_clk);
    #2;
    check_val("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ts_link_monitor.md
# ts_link_monitor

Receive-side alignment and link-quality monitor for one trigger-link lane, placed directly downstream of the dual-lane GTX wrapper and running in that lane's recovered `rx_clk` domain. It accepts the registered 16-bit word, K flags and error flag per recovered clock and finds the K28.5 (0xBC) comma byte position. It realigns the stream so the comma sits in byte 0 and runs a hunt/verify/locked state machine. It delivers the 8-bit payload byte (the transmitter's free-running counter) with a valid strobe, plus saturating error and unlock counters for slow control.

## Interface
- `LOCK_COUNT`, 16: consecutive good aligned words required to go from VERIFY to LOCKED (range 2..255).
- `UNLOCK_COUNT`, 4: consecutive bad aligned words in LOCKED that force HUNT (range 1..255).
- `CNT_WIDTH`, 16: width of every statistics counter.
- `rx_clk`  input  1  recovered lane clock (rxusrclk2); the only clock.
- `reset`  input  1  synchronous, active-high reset.
- `rx_d`  input  16  received word, byte 0 = [7:0].
- `rx_k`  input  2  per-byte K flags.
- `rx_err`  input  1  disparity or not-in-table error for this word.
- `clear_cnt`  input  1  synchronous clear of all statistics counters.
- `locked`  output  1  state == LOCKED.
- `align`  output  1  0: comma found in byte 0; 1: comma found in byte 1.
- `pay_d`  output  8  aligned payload byte.
- `pay_valid`  output  1  `pay_d` is from a good word in LOCKED.
- `code_err_cnt`  output  CNT_WIDTH  words received with `rx_err`=1.
- `seq_err_cnt`  output  CNT_WIDTH  payload sequence violations in LOCKED.
- `unlock_cnt`  output  CNT_WIDTH  LOCKED→HUNT transitions.

## Operation
- Stage register holds the previous `rx_d[15:8]` and `rx_k[1]`.
- Aligned word when `align`=0 is `{rx_d, rx_k}`. When `align`=1 it is data `{rx_d[7:0], prev_d_hi}` and K `{rx_k[0], prev_k_hi}`, with error = `rx_err | prev_err`.
- A word is good when the aligned K equals 2'b01, the aligned byte 0 equals 0xBC, and the error flag is 0. Otherwise it is bad.
- HUNT: a raw word with `rx_k`=01 and `rx_d[7:0]`=0xBC sets `align`←0. A raw word with `rx_k`=10 and `rx_d[15:8]`=0xBC sets `align`←1. Either event moves to VERIFY with good-count 1. Any other raw word, including `rx_k`=11, stays in HUNT.
- VERIFY: a good word increments good-count. When good-count reaches `LOCK_COUNT`, go to LOCKED. A bad word returns to HUNT. `align` is held.
- LOCKED: a good word clears miss-count. A bad word increments miss-count, and reaching `UNLOCK_COUNT` goes to HUNT and increments `unlock_cnt`.
- Sequence check, LOCKED only: the first good word after entry seeds the expected value. Each later good word must have aligned byte 1 equal to the previous good payload +1 mod 256; 0xFF→0x00 is legal. A mismatch increments `seq_err_cnt` and reseeds from the received value. It does not count as a bad word for lock purposes.
- `code_err_cnt` increments on every raw `rx_err`=1 cycle in any state.
- All counters saturate at all-ones. If `clear_cnt` and an increment occur in the same cycle, the clear wins and the counter reads 0.

## Timing
- Reset values: state HUNT, `locked`=0, `align`=0, `pay_d`=0x00, `pay_valid`=0, all counters 0, stage register 0.
- `pay_d` and `pay_valid` are registered, one `rx_clk` after the cycle that completes the aligned word. With `align`=1 that completing cycle is the cycle supplying byte 1.
- `locked` rises the cycle after the `LOCK_COUNT`-th good word. It falls the cycle after the `UNLOCK_COUNT`-th consecutive bad word.
- `pay_valid`=0 on the output cycle of any bad word and in HUNT and VERIFY.
- `reset` asserted mid-operation returns everything to reset values on the next edge, regardless of state.

## Configuration
- `TS_LINK_SEQ_CHECK_EN` defined: the sequence checker and `seq_err_cnt` are built as described.
- Undefined: no sequence logic is generated, `seq_err_cnt` is tied to 0, and lock and payload behaviour are unchanged.

## Test plan
- Aligned stream `{n,0xBC}`, K=01, n counting from 0x00, `LOCK_COUNT`=16 → `locked`=1 one cycle after word 16. `align`=0, `pay_d` follows n with `pay_valid`=1, all counters 0.
- Stream shifted one byte (comma in [15:8], K=10) → `align`=1 and lock after 16 words. `pay_d` is continuous including the 0xFF→0x00 wrap, and `seq_err_cnt`=0.
- While locked, inject 3 bad words (`rx_err`=1) then good words → `locked` stays 1, `code_err_cnt`=3, `pay_valid` is low for 3 outputs. Then inject 4 consecutive bad words → `locked`=0 and `unlock_cnt`=1.
- While locked, skip one counter value (0x10→0x12) → `seq_err_cnt`=1 and `locked` stays 1. Next 0x13 → no further increment.
- Drive `rx_err`=1 continuously for 2^16+5 cycles → `code_err_cnt`=0xFFFF. Pulse `clear_cnt` in the same cycle as an error → counter reads 0.
- Assert `reset` while LOCKED with nonzero counters → the next cycle shows HUNT, `locked`=0, and all outputs at reset values. Rebuild without `TS_LINK_SEQ_CHECK_EN` → `seq_err_cnt` stays 0 under the skip test.
